serial_loader: RTL and testbench

SERIAL_LOADER -- requirements
Module: serial_loader

---
 rtl/serial_loader_pkg.sv | 19 +
 rtl/serial_loader_bit_counter.sv | 34 +++
 rtl/serial_loader.sv | 124 ++++++++++++
 tb/tb_serial_loader.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_loader_pkg.sv
// Shared types and helpers for the serial_loader block: FSM state encoding
// and the even-parity decision.
package serial_loader_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2,
        DONE   = 2'd3
    } state_t;

    // word_parity is the XOR-reduction of the received word; even parity
    // fails when it disagrees with the transmitted parity bit.
    function automatic logic even_parity_fail(input logic word_parity,
                                              input logic parity_bit);
        return word_parity ^ parity_bit;
    endfunction

endpackage

// File: rtl/serial_loader_bit_counter.sv
// Bit counter for serial_loader: synchronous clear, increment enable and a
// terminal flag raised while the count sits at WIDTH-1.
module bit_counter #(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic terminal
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    logic [CNT_W-1:0] count;

    assign terminal = (count == CNT_W'(WIDTH - 1));

    // Wrap on the terminal increment so non-power-of-two widths stay in range.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            if (terminal) begin
                count <= '0;
            end else begin
                count <= count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/serial_loader.sv
// Serial-to-parallel loader: shifts in WIDTH bits MSB first and strobes load
// with a registered data_out. Optional even-parity check under PARITY_CHECK_EN.
module serial_loader #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sin_valid,
    input  logic             sin_bit,
    output logic             sin_ready,
    output logic             busy,
    output logic             load,
    output logic             err,
    output logic [WIDTH-1:0] data_out
);

    import serial_loader_pkg::*;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] shreg;
    logic             accept;
    logic             cnt_clr;
    logic             cnt_inc;
    logic             cnt_last;
    logic             perr;

    bit_counter #(
        .WIDTH(WIDTH)
    ) u_bit_counter (
        .clk     (clk),
        .rst     (rst),
        .clear   (cnt_clr),
        .inc     (cnt_inc),
        .terminal(cnt_last)
    );

    assign sin_ready = (state == SHIFT) || (state == PARITY);
    assign busy      = (state != IDLE);
    assign accept    = sin_valid && sin_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SHIFT;
                    cnt_clr   = 1'b1;
                end
            end
            SHIFT: begin
                if (accept) begin
                    cnt_inc = 1'b1;
                    if (cnt_last) begin
`ifdef PARITY_CHECK_EN
                        state_nxt = PARITY;
`else
                        state_nxt = DONE;
`endif
                    end
                end
            end
            PARITY: begin
                if (accept) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg <= '0;
        end else if ((state == SHIFT) && accept) begin
            shreg <= {shreg[WIDTH-2:0], sin_bit};
        end
    end

`ifdef PARITY_CHECK_EN
    // Parity verdict is latched when the parity bit arrives and consumed in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            perr <= 1'b0;
        end else if ((state == PARITY) && accept) begin
            perr <= even_parity_fail(^shreg, sin_bit);
        end else if (state == IDLE) begin
            perr <= 1'b0;
        end
    end

    assign err  = (state == DONE) && perr;
`else
    assign perr = 1'b0;
    assign err  = 1'b0;
`endif

    assign load = (state == DONE) && !perr;

    always_ff @(posedge clk) begin
        if (rst) begin
            data_out <= '0;
        end else if (load) begin
            data_out <= shreg;
        end
    end

endmodule

// File: tb/tb_serial_loader.sv
// Self-checking bench for serial_loader (WIDTH=8); parity scenarios are
// included when PARITY_CHECK_EN is defined.
module tb_serial_loader;

    localparam int WIDTH = 8;
`ifdef PARITY_CHECK_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             sin_valid;
    logic             sin_bit;
    logic             sin_ready;
    logic             busy;
    logic             load;
    logic             err;
    logic [WIDTH-1:0] data_out;

    int               checks = 0;
    int               errors = 0;
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] last_data = '0;

    serial_loader #(
        .WIDTH(WIDTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .sin_valid(sin_valid),
        .sin_bit  (sin_bit),
        .sin_ready(sin_ready),
        .busy     (busy),
        .load     (load),
        .err      (err),
        .data_out (data_out)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one frame: stall_after = bit index followed by 3 idle cycles
    // (-1 for none), glitch pulses start mid-SHIFT and in DONE.
    task automatic drive_frame(input logic [WIDTH-1:0] w, input int stall_after,
                               input bit glitch, input bit bad_par);
        logic [WIDTH-1:0] exp_w;
        bit               exp_load;
        exp_load = !bad_par;
        if (exp_load) exp_q.push_back(w);
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || sin_ready !== 1'b1) begin
            errors++;
            $display("FAIL frame_start busy=%b ready=%b expected 1 1", busy, sin_ready);
        end
        for (int i = 0; i < WIDTH; i++) begin
            sin_valid = 1'b1;
            sin_bit   = w[WIDTH-1-i];
            start     = glitch && (i == 3);
            tick();
            sin_valid = 1'b0;
            sin_bit   = ~sin_bit;
            start     = 1'b0;
            if (i == stall_after) begin
                for (int s = 0; s < 3; s++) begin
                    tick();
                    checks++;
                    if (sin_ready !== 1'b1 || load !== 1'b0 || busy !== 1'b1) begin
                        errors++;
                        $display("FAIL stall_cycle%0d ready=%b load=%b busy=%b expected 1 0 1",
                                 s, sin_ready, load, busy);
                    end
                end
            end
            if (i < WIDTH - 1 || PAR) begin
                checks++;
                if (load !== 1'b0 || err !== 1'b0) begin
                    errors++;
                    $display("FAIL early_strobe bit%0d load=%b err=%b expected 0 0", i, load, err);
                end
            end
        end
        if (PAR) begin
            sin_valid = 1'b1;
            sin_bit   = (^w) ^ bad_par;
            tick();
            sin_valid = 1'b0;
        end
        checks++;
        if (load !== exp_load || err !== bad_par) begin
            errors++;
            $display("FAIL done_strobe load=%b err=%b expected %b %b", load, err, exp_load, bad_par);
        end
        if (glitch) start = 1'b1;
        tick();
        start = 1'b0;
        exp_w = last_data;
        if (exp_load && exp_q.size() > 0) exp_w = exp_q.pop_front();
        last_data = exp_w;
        checks++;
        if (data_out !== exp_w) begin
            errors++;
            $display("FAIL data_out got %h expected %h", data_out, exp_w);
        end
        checks++;
        if (busy !== 1'b0 || load !== 1'b0 || err !== 1'b0 || sin_ready !== 1'b0) begin
            errors++;
            $display("FAIL after_done busy=%b load=%b err=%b ready=%b expected 0 0 0 0",
                     busy, load, err, sin_ready);
        end
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold busy=%b expected 0", busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (busy !== 1'b0 || load !== 1'b0 || err !== 1'b0 || sin_ready !== 1'b0
            || data_out !== '0) begin
            errors++;
            $display("FAIL reset_state busy=%b load=%b err=%b ready=%b data=%h expected all 0",
                     busy, load, err, sin_ready, data_out);
        end
        rst = 1'b0;
        start = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_start busy=%b expected 0", busy);
        end
    endtask

    task automatic test_basic();
        drive_frame(8'hA5, -1, 1'b0, 1'b0);
    endtask

    task automatic test_stall();
        drive_frame(8'h00, -1, 1'b0, 1'b0);
        drive_frame(8'hA5, 3, 1'b0, 1'b0);
    endtask

    task automatic test_reset_midframe();
        logic [WIDTH-1:0] w;
        w = 8'h3C;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sin_valid = 1'b1;
            sin_bit   = w[WIDTH-1-i];
            tick();
        end
        sin_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || sin_ready !== 1'b0 || load !== 1'b0 || err !== 1'b0
            || data_out !== '0) begin
            errors++;
            $display("FAIL mid_reset busy=%b ready=%b load=%b err=%b data=%h expected 0s",
                     busy, sin_ready, load, err, data_out);
        end
        last_data = '0;
        tick();
        checks++;
        if (load !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL post_reset load=%b busy=%b expected 0 0", load, busy);
        end
        drive_frame(8'hFF, -1, 1'b0, 1'b0);
    endtask

    task automatic test_start_ignored();
        drive_frame(8'h96, -1, 1'b1, 1'b0);
        drive_frame(8'h4B, 5, 1'b1, 1'b0);
    endtask

    task automatic test_parity();
        drive_frame(8'hA5, -1, 1'b0, 1'b0);
        drive_frame(8'h5A, -1, 1'b0, 1'b0);
        drive_frame(8'hA5, -1, 1'b0, 1'b1);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        sin_valid = 1'b0;
        sin_bit   = 1'b0;
        test_reset();
        test_basic();
        test_stall();
        test_reset_midframe();
        test_start_ignored();
        if (PAR) test_parity();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got %0d expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
